// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing / test-pattern generator:
// pattern modes, SVGA 800x600 default timing and the colour-bar table.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;

  // {r,g,b} on/off flags, left-most bar first
  localparam logic [2:0] BAR_COLORS [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Combinational test-pattern colour for one pixel position; black outside
// the active area.
module vga_pattern
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10
) (
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  logic [7:0]             frame,
  input  mode_e                  mode_q,
  input  logic [3*COLOR_W-1:0]   fg_rgb,
  output logic [3*COLOR_W-1:0]   rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic          active;
  logic [XW-1:0] bar_num;
  logic [2:0]    bar_idx;
  logic [2:0]    bar_flags;
  logic          on_grid;

  always_comb begin
    active    = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
    bar_num   = x / XW'(BAR_W);
    bar_idx   = (bar_num > XW'(7)) ? 3'd7 : bar_num[2:0];
    bar_flags = BAR_COLORS[bar_idx];
    on_grid   = (x[4:0] == '0) || (y[4:0] == '0);
    rgb       = '0;
    if (active) begin
      case (mode_q)
        MODE_SOLID: rgb = fg_rgb;
        MODE_BARS:  rgb = {{COLOR_W{bar_flags[2]}}, {COLOR_W{bar_flags[1]}},
                           {COLOR_W{bar_flags[0]}}};
        MODE_GRID:  rgb = on_grid ? fg_rgb : '0;
        MODE_RAMP:  rgb = {COLOR_W'(x + XW'(frame)), COLOR_W'(y), COLOR_W'(frame)};
        default:    rgb = '0;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator: pixel-enable divider, H/V/frame counters, sync decode
// and registered outputs one pixel behind the counters.
module vga_timing_pattern_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
  parameter int unsigned H_FP     = SVGA_H_FP,
  parameter int unsigned H_SYNC   = SVGA_H_SYNC,
  parameter int unsigned H_BP     = SVGA_H_BP,
  parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
  parameter int unsigned V_FP     = SVGA_V_FP,
  parameter int unsigned V_SYNC   = SVGA_V_SYNC,
  parameter int unsigned V_BP     = SVGA_V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned PCLK_DIV = 2,
  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  output logic                 hs,
  output logic                 vs,
  output logic                 de,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 frame_start,
  output logic                 pclk_mirror
);

  localparam int unsigned DW = $clog2(PCLK_DIV);

  logic [DW-1:0]        div_q, div_d;
  logic [XW-1:0]        h_q, h_d;
  logic [YW-1:0]        v_q, v_d;
  logic [7:0]           frame_q, frame_d;
  mode_e                mode_q, mode_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic                 de_q, de_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 frame_start_q, frame_start_d;
  logic                 pclk_q, pclk_d;

  logic                 pe;
  logic                 h_last;
  logic                 v_last;
  logic                 hs_on;
  logic                 vs_on;
  logic [3*COLOR_W-1:0] pat_rgb;

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COLOR_W  (COLOR_W),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern (
    .x      (h_q),
    .y      (v_q),
    .frame  (frame_q),
    .mode_q (mode_q),
    .fg_rgb (fg_rgb),
    .rgb    (pat_rgb)
  );

  always_comb begin
    pe     = (div_q == DW'(PCLK_DIV - 1));
    h_last = (32'(h_q) == H_TOTAL - 1);
    v_last = (32'(v_q) == V_TOTAL - 1);
    hs_on  = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_on  = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

    div_d         = pe ? '0 : div_q + 1'b1;
    h_d           = h_q;
    v_d           = v_q;
    frame_d       = frame_q;
    mode_d        = mode_q;
    x_d           = x_q;
    y_d           = y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    de_d          = de_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    pclk_d        = pclk_q;

    if (pe) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
        // New mode and frame number take effect together at pixel (0,0)
        if (v_last) begin
          frame_d = frame_q + 1'b1;
          mode_d  = mode_e'(mode);
        end
      end
      x_d           = h_q;
      y_d           = v_q;
      de_d          = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
      hs_d          = hs_on ? HS_POL : ~HS_POL;
      vs_d          = vs_on ? VS_POL : ~VS_POL;
      rgb_d         = pat_rgb;
      frame_start_d = (h_q == '0) && (v_q == '0);
      pclk_d        = 1'b0;
    end else if (div_q == DW'(PCLK_DIV / 2 - 1)) begin
      pclk_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      frame_q       <= '0;
      mode_q        <= mode_e'(mode);
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      pclk_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_q       <= frame_d;
      mode_q        <= mode_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      pclk_q        <= pclk_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign frame_start = frame_start_q;
  assign pclk_mirror = pclk_q;

endmodule
